// File: rtl/seriallite3_tx_burst_framer.sv
// seriallite3_tx_burst_framer: TX framer between a user packet stream and the
// SerialLite III user TX interface. It buffers words in a show-ahead FIFO and
// cuts packets into bursts of at most MAX_BURST beats. It drives SOB/EOB and the
// sync sideband, gates traffic on link_up_tx, and keeps link-abort and TX-error
// counters. Define SL3_FRAMER_STATS_EN to add the burst/word statistics
// counters and the stats_clear input.
module seriallite3_tx_burst_framer #(
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int SYNC_W     = 8
) (
  input  logic                  user_clock_tx,
  input  logic                  user_clock_reset_tx_n,
  input  logic [64*LANES-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [SYNC_W-1:0]     in_sync,
  output logic [64*LANES-1:0]   data_tx,
  output logic                  valid_tx,
  input  logic                  ready_tx,
  output logic                  start_of_burst_tx,
  output logic                  end_of_burst_tx,
  output logic [SYNC_W-1:0]     sync_tx,
  input  logic                  link_up_tx,
  input  logic [3:0]            error_tx,
`ifdef SL3_FRAMER_STATS_EN
  input  logic                  stats_clear,
  output logic [31:0]           burst_count,
  output logic [31:0]           word_count,
`endif
  output logic [7:0]            abort_count,
  output logic [15:0]           err_count
);

  localparam int DW = 64 * LANES;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef struct packed {
    logic              last;
    logic [SYNC_W-1:0] sync;
    logic [DW-1:0]     data;
  } entry_t;

  typedef enum logic [1:0] {S_DOWN, S_IDLE, S_BURST} state_t;

  entry_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [7:0]    abort_q;
  logic [15:0]   err_q;
  logic          flush, abort_inc;

  entry_t head;
  logic   full, empty, push, pop, eob;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_q];

  // Ready depends only on registered state, so there is no path from ready_tx.
  assign in_ready = !full && (state_q != S_DOWN);
  assign valid_tx = !empty && (state_q != S_DOWN);
  assign push     = in_valid && in_ready;
  assign pop      = valid_tx && ready_tx;
  assign eob      = valid_tx && (head.last || (beat_q == BW'(MAX_BURST - 1)));

  // Head fields are gated so the outputs read 0 whenever nothing is presented.
  assign data_tx           = valid_tx ? head.data : '0;
  assign sync_tx           = valid_tx ? head.sync : '0;
  assign start_of_burst_tx = valid_tx && (state_q == S_IDLE);
  assign end_of_burst_tx   = eob;
  assign abort_count       = abort_q;
  assign err_count         = err_q;

  // Next-state, beat tracking and the link-loss flush decision.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    flush     = 1'b0;
    abort_inc = 1'b0;
    unique case (state_q)
      S_DOWN: if (link_up_tx) state_d = S_IDLE;
      S_IDLE, S_BURST: begin
        if (!link_up_tx) begin
          state_d   = S_DOWN;
          beat_d    = '0;
          flush     = 1'b1;
          abort_inc = (state_q == S_BURST) || !empty;
        end else if (pop) begin
          if (eob) begin
            state_d = S_IDLE;
            beat_d  = '0;
          end else begin
            state_d = S_BURST;
            beat_d  = beat_q + BW'(1);
          end
        end
      end
      default: state_d = S_DOWN;
    endcase
  end

  // FSM state and beat counter.
  always_ff @(posedge user_clock_tx or negedge user_clock_reset_tx_n) begin
    if (!user_clock_reset_tx_n) begin
      state_q <= S_DOWN;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // FIFO storage; contents are never read while the entry count is zero.
  always_ff @(posedge user_clock_tx) begin
    if (push) mem_q[wr_q] <= '{last: in_last, sync: in_sync, data: in_data};
  end

  // FIFO pointers and occupancy. A link-loss flush discards everything.
  always_ff @(posedge user_clock_tx or negedge user_clock_reset_tx_n) begin
    if (!user_clock_reset_tx_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

`ifdef SL3_FRAMER_STATS_EN
  logic [31:0] burst_q, word_q;
  assign burst_count = burst_q;
  assign word_count  = word_q;

  // Saturating abort/error counters plus wrapping burst/word counters.
  always_ff @(posedge user_clock_tx or negedge user_clock_reset_tx_n) begin
    if (!user_clock_reset_tx_n) begin
      abort_q <= '0;
      err_q   <= '0;
      burst_q <= '0;
      word_q  <= '0;
    end else if (stats_clear) begin
      abort_q <= '0;
      err_q   <= '0;
      burst_q <= '0;
      word_q  <= '0;
    end else begin
      if (abort_inc && (abort_q != '1))       abort_q <= abort_q + 8'd1;
      if ((error_tx != '0) && (err_q != '1))  err_q   <= err_q + 16'd1;
      if (pop && eob)                         burst_q <= burst_q + 32'd1;
      if (pop)                                word_q  <= word_q + 32'd1;
    end
  end
`else
  // Saturating abort/error counters, cleared only by reset.
  always_ff @(posedge user_clock_tx or negedge user_clock_reset_tx_n) begin
    if (!user_clock_reset_tx_n) begin
      abort_q <= '0;
      err_q   <= '0;
    end else begin
      if (abort_inc && (abort_q != '1))       abort_q <= abort_q + 8'd1;
      if ((error_tx != '0) && (err_q != '1))  err_q   <= err_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seriallite3_tx_burst_framer.sv
// Directed bench for seriallite3_tx_burst_framer (LANES=2, FIFO_DEPTH=8,
// MAX_BURST=4). Inputs change 1 time unit after the rising edge, and outputs
// are checked at that same point.
module tb_seriallite3_tx_burst_framer;
  localparam int LANES = 2;
  localparam int DW    = 64 * LANES;
  localparam int SW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready, in_last;
  logic [SW-1:0] in_sync;
  logic [DW-1:0] data_tx;
  logic          valid_tx, ready_tx, sob, eob, link_up;
  logic [SW-1:0] sync_tx;
  logic [3:0]    error_tx;
  logic [7:0]    abort_count;
  logic [15:0]   err_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seriallite3_tx_burst_framer #(
    .LANES(LANES), .FIFO_DEPTH(8), .MAX_BURST(4), .SYNC_W(SW)
  ) dut (
    .user_clock_tx(clk), .user_clock_reset_tx_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_sync(in_sync),
    .data_tx(data_tx), .valid_tx(valid_tx), .ready_tx(ready_tx),
    .start_of_burst_tx(sob), .end_of_burst_tx(eob), .sync_tx(sync_tx),
    .link_up_tx(link_up), .error_tx(error_tx),
    .abort_count(abort_count), .err_count(err_count)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    in_sync  = d[SW-1:0] ^ 8'hA5;
  endtask

  initial begin
    logic [DW-1:0] w;
    rst_n = 1'b0; link_up = 1'b0; ready_tx = 1'b0; error_tx = 4'h0;
    drive(1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    check("rst_valid", valid_tx, 0);
    check("rst_ready", in_ready, 0);
    check("rst_sob", sob, 0);
    check("rst_eob", eob, 0);
    check("rst_data", data_tx, 0);
    check("rst_abort", abort_count, 0);
    check("rst_err", err_count, 0);

    rst_n = 1'b1; link_up = 1'b1;
    step();
    check("up_ready", in_ready, 1);
    check("up_valid", valid_tx, 0);

    // 3-word packet, sink always ready: each word appears the cycle after acceptance.
    ready_tx = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      w = DW'(32'h100 + k);
      check("t1_inready", in_ready, 1);
      drive(1'b1, w, k == 3);
      step();
      check("t1_valid", valid_tx, 1);
      check("t1_data", data_tx, w);
      check("t1_sync", sync_tx, DW'(w[SW-1:0] ^ 8'hA5));
      check("t1_sob", sob, DW'(k == 1));
      check("t1_eob", eob, DW'(k == 3));
    end
    drive(1'b0, '0, 1'b0);
    step();
    check("t1_drained", valid_tx, 0);

    // 10-word packet with MAX_BURST=4: bursts 4,4,2.
    for (int k = 1; k <= 10; k++) begin
      w = DW'(32'h200 + k);
      drive(1'b1, w, k == 10);
      step();
      check("t2_data", data_tx, w);
      check("t2_sob", sob, DW'((k == 1) || (k == 5) || (k == 9)));
      check("t2_eob", eob, DW'((k == 4) || (k == 8) || (k == 10)));
    end
    drive(1'b0, '0, 1'b0);
    step();
    check("t2_drained", valid_tx, 0);

    // Back-to-back single-word packets: SOB and EOB together, state stays IDLE.
    for (int k = 0; k < 2; k++) begin
      w = DW'(32'h300 + k);
      drive(1'b1, w, 1'b1);
      step();
      check("t3_data", data_tx, w);
      check("t3_sob", sob, 1);
      check("t3_eob", eob, 1);
    end
    drive(1'b0, '0, 1'b0);
    step();
    check("t3_drained", valid_tx, 0);

    // Backpressure for 20 cycles: FIFO fills to 8, head is held stable.
    ready_tx = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("t4_inready", in_ready, 1);
      drive(1'b1, DW'(32'h400 + k), k == 8);
      step();
      check("t4_hold_data", data_tx, DW'(32'h401));
      check("t4_hold_sob", sob, 1);
    end
    check("t4_full", in_ready, 0);
    drive(1'b0, '0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      step();
      check("t4_stall_data", data_tx, DW'(32'h401));
      check("t4_stall_sob", sob, 1);
      check("t4_stall_eob", eob, 0);
      check("t4_stall_ready", in_ready, 0);
    end
    ready_tx = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("t4_drain_valid", valid_tx, 1);
      check("t4_drain_data", data_tx, DW'(32'h400 + k));
      check("t4_drain_sob", sob, DW'((k == 1) || (k == 5)));
      check("t4_drain_eob", eob, DW'((k == 4) || (k == 8)));
      step();
    end
    check("t4_empty", valid_tx, 0);

    // Link drop mid-burst with 5 words queued.
    ready_tx = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, DW'(32'h500 + k), 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0);
    check("t5_head", data_tx, DW'(32'h501));
    ready_tx = 1'b1;
    step();
    check("t5_second", data_tx, DW'(32'h502));
    check("t5_mid_sob", sob, 0);
    ready_tx = 1'b0;
    link_up  = 1'b0;
    check("t5_abort_pre", abort_count, 0);
    step();
    check("t5_down_valid", valid_tx, 0);
    check("t5_down_ready", in_ready, 0);
    check("t5_down_data", data_tx, 0);
    check("t5_abort", abort_count, 1);
    step();
    check("t5_abort_once", abort_count, 1);
    link_up = 1'b1;
    step();
    check("t5_relink_ready", in_ready, 1);
    check("t5_flushed", valid_tx, 0);
    drive(1'b1, DW'(32'h600), 1'b1);
    ready_tx = 1'b1;
    step();
    check("t5_new_data", data_tx, DW'(32'h600));
    check("t5_new_sob", sob, 1);
    check("t5_new_eob", eob, 1);
    drive(1'b0, '0, 1'b0);
    step();
    check("t5_new_done", valid_tx, 0);

    // Dropping the link while idle with an empty FIFO is not an abort.
    link_up = 1'b0;
    step();
    check("t5_idle_drop", abort_count, 1);
    link_up = 1'b1;
    step();

    // Error counting and saturation.
    check("t6_err0", err_count, 0);
    error_tx = 4'h2;
    repeat (3) step();
    error_tx = 4'h0;
    check("t6_err3", err_count, 3);
    step();
    check("t6_err_hold", err_count, 3);
    error_tx = 4'h1;
    repeat (65531) step();
    error_tx = 4'h0;
    check("t6_err_fffe", err_count, 16'hFFFE);
    error_tx = 4'h8;
    repeat (5) step();
    error_tx = 4'h0;
    check("t6_err_sat", err_count, 16'hFFFF);
    step();
    check("t6_err_sat_hold", err_count, 16'hFFFF);
    check("t6_abort_final", abort_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
